// File: rtl/freq_period_meter_pkg.sv
// Shared definitions for the frequency/period meter.
//   state_e  : measurement FSM state encoding (IDLE, MEASURE, LOST)
//   PERIOD_W : width of period values in clk cycles, shared with the tone generator
package freq_period_meter_pkg;

   localparam int unsigned PERIOD_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOST    = 2'd2
   } state_e;

endpackage

// File: rtl/freq_period_meter_if.sv
// Result bundle of the frequency/period meter.
//   period_out   : averaged period in clk cycles, 0 = silence
//   high_out     : high time of the last accepted period
//   period_valid : one-cycle strobe, outputs change on this cycle
//   signal_lost  : level, high while the input is considered lost
// master = meter side (drives), slave = consumer side.
interface freq_period_meter_if;
   import freq_period_meter_pkg::*;

   logic [PERIOD_W-1:0] period_out;
   logic [PERIOD_W-1:0] high_out;
   logic                period_valid;
   logic                signal_lost;

   modport master (
      output period_out,
      output high_out,
      output period_valid,
      output signal_lost
   );

   modport slave (
      input period_out,
      input high_out,
      input period_valid,
      input signal_lost
   );

endinterface

// File: rtl/freq_period_meter_sig_sync_edge.sv
// Synchronizer plus rising-edge detector for an asynchronous input.
//   clk    : system clock
//   resetn : asynchronous active-low reset, clears all flops
//   in_sig : asynchronous input
//   s      : synchronized input (SYNC_STAGES flops, SYNC_STAGES >= 2)
//   rise   : s is 1 and was 0 on the previous cycle
module freq_period_meter_sig_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic in_sig,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_prev_q, s_prev_d;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], in_sig};
      s_prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q   <= '0;
         s_prev_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         s_prev_q <= s_prev_d;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_prev_q;

endmodule

// File: rtl/freq_period_meter.sv
// Measures period and high time (in clk cycles) of a square-wave input,
// averaging the period over 2^AVG_LOG2 accepted periods.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   in_sig : asynchronous square-wave input
//   enable : measurement enable; 0 discards the current window
//   meas   : result bundle (period_out, high_out, period_valid, signal_lost)
module freq_period_meter
   import freq_period_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned MIN_PERIOD  = 8,
   parameter int unsigned MAX_PERIOD  = 1000000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_sig,
   input  logic                  enable,
   freq_period_meter_if.master   meas
);

   localparam int unsigned SUM_W = PERIOD_W + AVG_LOG2;
   localparam int unsigned N_W   = AVG_LOG2 + 1;

   localparam logic [N_W-1:0]      WIN_N = N_W'(1 << AVG_LOG2);
   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

   logic s, rise;

   freq_period_meter_sig_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sig_sync_edge (
      .clk    (clk),
      .resetn (resetn),
      .in_sig (in_sig),
      .s      (s),
      .rise   (rise)
   );

   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [N_W-1:0]      n_q, n_d;
   logic [PERIOD_W-1:0] period_out_q, period_out_d;
   logic [PERIOD_W-1:0] high_out_q, high_out_d;
   logic                period_valid_q, period_valid_d;
   logic                signal_lost_q, signal_lost_d;

   // Values the window would take if the current rise is accepted.
   logic [SUM_W-1:0]    sum_acc;
   logic [N_W-1:0]      n_acc;
   logic [PERIOD_W-1:0] last_high;
   logic                accept_edge;
   logic                timeout;

   assign sum_acc     = sum_q + SUM_W'(cnt_q);
   assign n_acc       = n_q + N_W'(1);
   assign last_high   = hi_cnt_q + PERIOD_W'(s);
   assign accept_edge = rise && (cnt_q >= MIN_P);
   assign timeout     = (cnt_q >= MAX_P);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hi_cnt_d       = hi_cnt_q;
      sum_d          = sum_q;
      n_d            = n_q;
      period_out_d   = period_out_q;
      high_out_d     = high_out_q;
      period_valid_d = 1'b0;
      signal_lost_d  = signal_lost_q;

      if (!enable) begin
         state_d       = IDLE;
         cnt_d         = '0;
         hi_cnt_d      = '0;
         sum_d         = '0;
         n_d           = '0;
         signal_lost_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d  = MEASURE;
                  cnt_d    = PERIOD_W'(1);
                  hi_cnt_d = '0;
                  sum_d    = '0;
                  n_d      = '0;
               end
            end

            MEASURE: begin
               if (cnt_q < MAX_P) begin
                  cnt_d = cnt_q + PERIOD_W'(1);
               end
               if (s) begin
                  hi_cnt_d = hi_cnt_q + PERIOD_W'(1);
               end

               // An accepted rise takes priority over the timeout, so a period
               // of exactly MAX_PERIOD is still measured.
               if (accept_edge) begin
                  cnt_d    = PERIOD_W'(1);
                  hi_cnt_d = '0;
                  if (n_acc == WIN_N) begin
                     period_out_d   = PERIOD_W'(sum_acc >> AVG_LOG2);
                     high_out_d     = last_high;
                     period_valid_d = 1'b1;
                     sum_d          = '0;
                     n_d            = '0;
                  end else begin
                     sum_d = sum_acc;
                     n_d   = n_acc;
                  end
               end else if (timeout) begin
                  state_d        = LOST;
                  signal_lost_d  = 1'b1;
                  period_out_d   = '0;
                  high_out_d     = '0;
                  period_valid_d = 1'b1;
                  sum_d          = '0;
                  n_d            = '0;
               end
            end

            LOST: begin
               if (rise) begin
                  state_d       = MEASURE;
                  signal_lost_d = 1'b0;
                  cnt_d         = PERIOD_W'(1);
                  hi_cnt_d      = '0;
                  sum_d         = '0;
                  n_d           = '0;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         hi_cnt_q       <= '0;
         sum_q          <= '0;
         n_q            <= '0;
         period_out_q   <= '0;
         high_out_q     <= '0;
         period_valid_q <= 1'b0;
         signal_lost_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         hi_cnt_q       <= hi_cnt_d;
         sum_q          <= sum_d;
         n_q            <= n_d;
         period_out_q   <= period_out_d;
         high_out_q     <= high_out_d;
         period_valid_q <= period_valid_d;
         signal_lost_q  <= signal_lost_d;
      end
   end

   assign meas.period_out   = period_out_q;
   assign meas.high_out     = high_out_q;
   assign meas.period_valid = period_valid_q;
   assign meas.signal_lost  = signal_lost_q;

endmodule

// File: tb/tb_freq_period_meter.sv
// Bench for freq_period_meter: random and directed square waves, reference
// model working on edge timestamps, strobe scoreboard checked at negedge.
module tb_freq_period_meter;

   localparam int unsigned SS   = 2;
   localparam int unsigned AL   = 2;
   localparam int          MINP = 8;
   localparam int          MAXP = 1000;
   localparam int          WINN = 4;

   logic clk = 1'b0;
   logic resetn;
   logic in_sig;
   logic enable;

   freq_period_meter_if ifc ();

   freq_period_meter #(
      .SYNC_STAGES (SS),
      .AVG_LOG2    (AL),
      .MIN_PERIOD  (MINP),
      .MAX_PERIOD  (MAXP)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .in_sig (in_sig),
      .enable (enable),
      .meas   (ifc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int      cyc;
      longint  period;
      longint  high;
   } exp_t;

   exp_t exp_q[$];
   bit   in_hist[int];
   bit   lost_at[int];

   // Reference model: tracks time of the last accepted rise and the input
   // samples seen since then; periods are timestamp differences.
   int   vf;
   int   m_state;          // 0 idle, 1 measuring, 2 lost
   int   t_acc;
   int   periods[$];
   bit   hist[$];
   bit   m_lost;

   task automatic check(string name, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic bit s_of(int k);
      if (k < vf + int'(SS)) return 1'b0;
      return in_hist[k - int'(SS)];
   endfunction

   task automatic model_step(int c, bit en);
      bit sn, sp, rise;
      sn   = s_of(c);
      sp   = s_of(c - 1);
      rise = sn & ~sp;
      if (!en) begin
         m_state = 0;
         periods.delete();
         m_lost  = 1'b0;
      end else begin
         case (m_state)
            0: if (rise) begin
               m_state = 1;
               t_acc   = c;
               hist.delete();
               periods.delete();
            end
            1: if (rise && (c - t_acc) >= MINP) begin
               int   h;
               exp_t e;
               longint tot;
               h = 0;
               foreach (hist[i]) h += int'(hist[i]);
               periods.push_back(c - t_acc);
               t_acc = c;
               hist.delete();
               if (periods.size() == WINN) begin
                  tot = 0;
                  foreach (periods[i]) tot += periods[i];
                  e.cyc    = c + 1;
                  e.period = tot / WINN;
                  e.high   = h;
                  exp_q.push_back(e);
                  periods.delete();
               end
            end else if ((c - t_acc) >= MAXP) begin
               exp_t e;
               m_state = 2;
               m_lost  = 1'b1;
               periods.delete();
               e.cyc    = c + 1;
               e.period = 0;
               e.high   = 0;
               exp_q.push_back(e);
            end
            default: if (rise) begin
               m_state = 1;
               m_lost  = 1'b0;
               t_acc   = c;
               hist.delete();
               periods.delete();
            end
         endcase
      end
      if (m_state == 1) hist.push_back(sn);
      lost_at[c + 1] = m_lost;
   endtask

   task automatic reset_model();
      vf      = cyc;
      m_state = 0;
      m_lost  = 1'b0;
      periods.delete();
      hist.delete();
      lost_at[cyc] = 1'b0;
   endtask

   task automatic step(bit v, bit en);
      in_sig       = v;
      enable       = en;
      in_hist[cyc] = v;
      model_step(cyc, en);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_period(int p, int h, bit en);
      for (int i = 0; i < p; i++) step(i < h, en);
   endtask

   task automatic glitch_period(int p, int h, int g_hi, int g_lo);
      for (int i = 0; i < p; i++) begin
         if (i < g_hi)             step(1'b1, 1'b1);
         else if (i < g_hi + g_lo) step(1'b0, 1'b1);
         else if (i < h)           step(1'b1, 1'b1);
         else                      step(1'b0, 1'b1);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_period_out",   longint'(ifc.period_out),   0);
      check("rst_high_out",     longint'(ifc.high_out),     0);
      check("rst_period_valid", longint'(ifc.period_valid), 0);
      check("rst_signal_lost",  longint'(ifc.signal_lost),  0);
   endtask

   // Monitor: every cycle, strobe presence/absence and signal_lost level,
   // and on a strobe the popped expected result.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (lost_at.exists(cyc))
            check("signal_lost", longint'(ifc.signal_lost), longint'(lost_at[cyc]));
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("period_valid_strobe", longint'(ifc.period_valid), 1);
            check("period_out", longint'(ifc.period_out), e.period);
            check("high_out",   longint'(ifc.high_out),   e.high);
         end else begin
            check("period_valid_quiet", longint'(ifc.period_valid), 0);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      in_sig = 1'b0;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      resetn = 1'b1;
      reset_model();

      repeat (10) step(1'b0, 1'b1);

      // steady 100/50
      repeat (9) pulse_period(100, 50, 1'b1);

      // alternating 100/102
      repeat (4) begin
         pulse_period(100, 50, 1'b1);
         pulse_period(102, 51, 1'b1);
      end

      // glitch inside the high phase
      repeat (6) glitch_period(100, 50, 3, 2);

      // timeout then recovery
      pulse_period(100, 50, 1'b1);
      repeat (1100) step(1'b0, 1'b1);
      repeat (6) pulse_period(100, 50, 1'b1);

      // enable dropped mid-window
      repeat (3) pulse_period(100, 50, 1'b1);
      repeat (20) step(1'b0, 1'b0);
      repeat (6) pulse_period(100, 50, 1'b1);

      // rise exactly at MAX_PERIOD is a period, not a timeout
      repeat (5) pulse_period(MAXP, MAXP / 2, 1'b1);

      // asynchronous reset mid-window
      repeat (2) pulse_period(100, 50, 1'b1);
      repeat (30) step(1'b1, 1'b1);
      check("queue_empty_before_reset", exp_q.size(), 0);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_outputs();
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      reset_model();
      repeat (10) pulse_period(100, 50, 1'b1);

      // randomized waveforms
      for (int it = 0; it < 80; it++) begin
         int r, p, h, gh, gl;
         r = int'($urandom_range(0, 11));
         if (r == 0) begin
            p  = int'($urandom_range(20, 250));
            gh = int'($urandom_range(1, 3));
            gl = int'($urandom_range(1, 3));
            h  = int'($urandom_range(gh + gl + 1, p - 1));
            glitch_period(p, h, gh, gl);
         end else if (r == 1) begin
            p = int'($urandom_range(3, 7));
            pulse_period(p, 1, 1'b1);
         end else if (r == 2) begin
            repeat (int'($urandom_range(1, 10))) step(1'b0, 1'b0);
         end else if (r == 3 && it % 4 == 0) begin
            repeat (int'($urandom_range(990, 1050))) step(1'b0, 1'b1);
         end else begin
            p = int'($urandom_range(MINP, 300));
            h = int'($urandom_range(1, p - 1));
            pulse_period(p, h, 1'b1);
         end
      end

      repeat (20) step(1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b0);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/freq_period_meter.md
Name: freq_period_meter

Overview:
Measures the period and high time, in clk cycles, of a square-wave input such as a comparator-squared microphone signal or a loopback from the tone generator. Its output is in the same clks-per-period units the tone generator consumes, so the pitch-training logic can compare a sung or played pitch against the target. Each result is averaged over 2^AVG_LOG2 periods. Outputs are reported with a one-cycle valid strobe; a reported period of 0 means silence.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the asynchronous input (minimum 2).
AVG_LOG2, 2, log2 of the number of periods averaged per result.
MIN_PERIOD, 8, shortest accepted period; rising edges arriving sooner are treated as glitches.
MAX_PERIOD, 1000000, cycles without an accepted edge before the signal is declared lost.

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
in_sig  in  1  asynchronous square-wave input
enable  in  1  measurement enable
period_out  out  32  averaged period in clk cycles; 0 = silence
high_out  out  32  high time of the last accepted period, not averaged
period_valid  out  1  one-cycle pulse; period_out and high_out change on the same cycle
signal_lost  out  1  level; 1 while in the LOST state

Behaviour:
- Reset (async, active-low):
  - all outputs are 0 and the synchronizer flops are 0;
  - state = IDLE; counters and accumulator are cleared.
- Input path:
  - in_sig passes through SYNC_STAGES flops to give s.
  - rise = s & ~s_prev.
- Counters:
  - cnt: set to 1 on every accepted edge, otherwise increments by 1 each cycle.
  - hi_cnt: set to 0 on an accepted edge, otherwise increments on each cycle where s = 1.
  - The measured period is cnt on the cycle of the next accepted edge. Example: edges at cycle 0 and cycle P give P.
- States:
  - IDLE:
    - Waits for enable = 1 and a rise.
    - That first rise is accepted, starts counting and moves to MEASURE.
    - It does not produce a result.
  - MEASURE:
    - A rise with cnt < MIN_PERIOD is ignored; cnt and hi_cnt keep running.
    - A rise with cnt >= MIN_PERIOD is accepted:
      - sum += cnt;
      - last_high = hi_cnt plus 1 if s = 1 on that cycle;
      - n increments.
    - When n reaches 2^AVG_LOG2, on the clock edge after that accepted rise:
      - period_out <= sum >> AVG_LOG2 (truncating);
      - high_out <= last_high;
      - period_valid = 1 for one cycle;
      - sum and n are cleared.
    - Timeout: cnt == MAX_PERIOD with no rise on that cycle leads to LOST on the next cycle:
      - period_out <= 0 and high_out <= 0;
      - period_valid pulses once;
      - sum and n are cleared.
    - Simultaneous rise and cnt == MAX_PERIOD: the rise wins and is accepted as period MAX_PERIOD.
  - LOST:
    - signal_lost = 1.
    - The first rise is accepted, clears signal_lost, and moves to MEASURE with a new averaging window. No result is produced on that edge.
- enable = 0 in any state:
  - next state is IDLE;
  - sum, n and cnt are cleared and the partial window is discarded;
  - signal_lost is cleared;
  - period_out and high_out hold their values;
  - no strobe is produced.
- Arithmetic:
  - sum is 32+AVG_LOG2 bits wide and cannot overflow.
  - cnt never exceeds MAX_PERIOD.
- Latency: one clk from the final accepted edge of a window to period_valid. The synchronizer adds SYNC_STAGES+1 cycles from in_sig.
- Reset asserted mid-window: immediately returns everything to the reset values above.

Decomposition:
- Shared package holds:
  - the 2-bit state encoding: IDLE, MEASURE, LOST;
  - the PERIOD_W = 32 width constant, shared with the tone generator.
- One sub-module, sig_sync_edge: parameterized synchronizer plus rising-edge detector. Outputs s and rise.

Test Plan:
- Steady square wave, period 100, high 50, enable = 1:
  - first period_valid comes after 5 rises (1 arming + 4 periods);
  - period_out = 100, high_out = 50;
  - later strobes follow every 400 cycles.
- Alternating periods 100, 102, 100, 102 -> period_out = 101.
- Glitch, period 100: after an accepted rise the input goes high 3 / low 2 / high to cycle 50.
  - The second rise at cnt = 5 is ignored.
  - period_out = 100, high_out = 48.
- Timeout with MAX_PERIOD = 1000, input held low after an edge:
  - exactly 1000 cycles later, signal_lost = 1 and period_valid pulses with period_out = 0;
  - when toggling resumes, signal_lost clears on the first rise and the next strobe comes 4 periods later.
- Enable and timeout interaction: enable dropped after 2 periods of a window -> no strobe. Re-enable needs 5 new rises before a strobe. A rise on the same cycle that cnt reaches MAX_PERIOD is accepted with no timeout.
- resetn pulsed low mid-window -> all outputs read 0 immediately, with no clock needed.
